// File: rtl/cnt_ctrl_pkg.sv
// Shared types and constants for the cnt_ctrl counter sequencer.
// Optional overrun flag is enabled elsewhere by defining CNT_CTRL_OVERRUN_EN.
package cnt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;
    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;

endpackage

// File: rtl/cnt_ctrl_if.sv
// Host <-> cnt_ctrl command/status bundle; the host drives the master side.
// The ovr status line exists only when CNT_CTRL_OVERRUN_EN is defined.
interface cnt_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             mode;
    logic             dir;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             done;
    logic [1:0]       state;
`ifdef CNT_CTRL_OVERRUN_EN
    logic             ovr;

    modport master (
        output start, stop, pause, mode, dir, limit,
        input  count, busy, tc, done, state, ovr
    );
    modport slave (
        input  start, stop, pause, mode, dir, limit,
        output count, busy, tc, done, state, ovr
    );
`else
    modport master (
        output start, stop, pause, mode, dir, limit,
        input  count, busy, tc, done, state
    );
    modport slave (
        input  start, stop, pause, mode, dir, limit,
        output count, busy, tc, done, state
    );
`endif
endinterface

// File: rtl/cnt_ctrl_core.sv
// Plain synchronous up/down counter with parallel load; load beats enable.
module cnt_core
    import cnt_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] count
);

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= (dir == DIR_DOWN) ? count - 1'b1 : count + 1'b1;
        end
    end

endmodule

// File: rtl/cnt_ctrl.sv
// Sequencer driving a cnt_core: start/stop/pause control, one-shot or auto-reload, up or down.
// Define CNT_CTRL_OVERRUN_EN to add the sticky ovr flag (start seen while busy).
module cnt_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    cnt_ctrl_if.slave  bus
);

    state_t           state_q, state_d;
    logic             mode_q, dir_q;
    logic [WIDTH-1:0] limit_q;

    logic [WIDTH-1:0] count;
    logic             core_load, core_en;
    logic [WIDTH-1:0] core_load_val;

    logic [WIDTH-1:0] term_val, reload_val;
    logic             at_term, step, accept_start, in_busy;

    assign term_val     = (dir_q == DIR_DOWN) ? '0 : limit_q;
    assign reload_val   = (dir_q == DIR_DOWN) ? limit_q : '0;
    assign at_term      = (count == term_val);
    assign in_busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign accept_start = bus.start && !bus.stop &&
                          ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // A PAUSE cycle only delays the pending RUN step; releasing pause performs it.
    assign step         = in_busy && !bus.stop && !bus.pause;

    // NOTE: every clocked block uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q  <= MODE_ONESHOT;
            dir_q   <= DIR_UP;
            limit_q <= '0;
        end else if (accept_start) begin
            mode_q  <= bus.mode;
            dir_q   <= bus.dir;
            limit_q <= bus.limit;
        end
    end

    // NOTE: each combinational block assigns defaults first so no path leaves a variable unassigned (no latches).
    always_comb begin
        state_d = state_q;
        if (bus.stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) state_d = ST_RUN;
                end
                ST_RUN, ST_PAUSE: begin
                    if (bus.pause)
                        state_d = ST_PAUSE;
                    else if (at_term && mode_q == MODE_ONESHOT)
                        state_d = ST_DONE;
                    else
                        state_d = ST_RUN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        core_load     = 1'b0;
        core_load_val = '0;
        core_en       = 1'b0;
        if (bus.stop) begin
            core_load = 1'b1;
        end else if (accept_start) begin
            core_load     = 1'b1;
            core_load_val = (bus.dir == DIR_DOWN) ? bus.limit : '0;
        end else if (step) begin
            if (!at_term) begin
                core_en = 1'b1;
            end else if (mode_q == MODE_RELOAD) begin
                core_load     = 1'b1;
                core_load_val = reload_val;
            end
        end

        bus.tc    = (state_q == ST_RUN) && at_term;
        bus.busy  = in_busy;
        bus.done  = (state_q == ST_DONE);
        bus.state = state_q;
        bus.count = count;
    end

    cnt_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .load_val (core_load_val),
        .en       (core_en),
        .dir      (dir_q),
        .count    (count)
    );

`ifdef CNT_CTRL_OVERRUN_EN
    logic ovr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovr_q <= 1'b0;
        end else if (bus.stop) begin
            ovr_q <= 1'b0;
        end else if (bus.start && in_busy) begin
            ovr_q <= 1'b1;
        end
    end

    assign bus.ovr = ovr_q;
`endif

endmodule
